sudoku_cursor_ctrl: RTL and testbench



---
 rtl/sudoku_cursor_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sudoku_cursor_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_cursor_ctrl.sv
// rtl/sudoku_cursor_ctrl.sv - Sudoku grid cursor with hold-to-auto-repeat and select request
//
// Purpose: tracks the selected cell of a GRID x GRID board from conditioned
// button inputs, auto-repeats a held direction, and issues a one-cycle select
// request carrying the pre-move cursor position.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   btn_level     conditioned levels   {center, right, left, down, up}
//   btn_pulse     one-cycle press pulses, same bit order
//   cursor_row    current row, 0 = top
//   cursor_col    current column, 0 = left
//   move_strobe   one-cycle pulse, cursor changed this cycle
//   select_strobe one-cycle pulse, center was pressed
//   sel_row       row latched with select_strobe
//   sel_col       column latched with select_strobe
//   repeat_active high while auto-repeating
module sudoku_cursor_ctrl #(
  parameter int GRID          = 9,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 15_000_000,
  parameter int WRAP          = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_level,
  input  logic [4:0] btn_pulse,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       move_strobe,
  output logic       select_strobe,
  output logic [3:0] sel_row,
  output logic [3:0] sel_col,
  output logic       repeat_active
);

  localparam logic [3:0]  MID       = 4'((GRID - 1) / 2);
  localparam logic [3:0]  LAST      = 4'(GRID - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  dir_q, dir_d;
  logic [3:0]  row_q, row_d, col_q, col_d;
  logic [3:0]  sel_row_q, sel_row_d, sel_col_q, sel_col_d;
  logic        move_q, move_d, select_q, select_d;

  logic [3:0]  dir_level;
  logic [1:0]  new_dir;
  logic [1:0]  step_dir;
  logic        step_en;
  logic        unused_center_level;

  assign dir_level           = btn_level[3:0];
  assign unused_center_level = btn_level[4];

  // Fixed priority up > down > left > right; losers are simply dropped.
  always_comb begin
    new_dir = 2'd3;
    if (btn_pulse[0])      new_dir = 2'd0;
    else if (btn_pulse[1]) new_dir = 2'd1;
    else if (btn_pulse[2]) new_dir = 2'd2;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
    row_d     = row_q;
    col_d     = col_q;
    move_d    = 1'b0;
    select_d  = btn_pulse[4];
    sel_row_d = sel_row_q;
    sel_col_d = sel_col_q;
    step_en   = 1'b0;
    step_dir  = dir_q;

    // Select reports the position seen this cycle, before any move lands.
    if (btn_pulse[4]) begin
      sel_row_d = row_q;
      sel_col_d = col_q;
    end

    // New press beats level drop, which beats timer expiry.
    if (|btn_pulse[3:0]) begin
      step_en  = 1'b1;
      step_dir = new_dir;
      dir_d    = new_dir;
      timer_d  = '0;
      state_d  = HOLD;
    end else if (state_q != IDLE) begin
      if (!dir_level[dir_q]) begin
        state_d = IDLE;
        timer_d = '0;
      end else if (timer_q == ((state_q == HOLD) ? HOLD_LAST : REP_LAST)) begin
        step_en = 1'b1;
        timer_d = '0;
        state_d = REPEAT;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end

    // With clamping, an edge move is swallowed but the FSM still advanced.
    if (step_en) begin
      case (step_dir)
        2'd0: begin
          if (row_q != 4'd0) begin row_d = row_q - 4'd1; move_d = 1'b1; end
          else if (WRAP != 0) begin row_d = LAST; move_d = 1'b1; end
        end
        2'd1: begin
          if (row_q != LAST) begin row_d = row_q + 4'd1; move_d = 1'b1; end
          else if (WRAP != 0) begin row_d = 4'd0; move_d = 1'b1; end
        end
        2'd2: begin
          if (col_q != 4'd0) begin col_d = col_q - 4'd1; move_d = 1'b1; end
          else if (WRAP != 0) begin col_d = LAST; move_d = 1'b1; end
        end
        default: begin
          if (col_q != LAST) begin col_d = col_q + 4'd1; move_d = 1'b1; end
          else if (WRAP != 0) begin col_d = 4'd0; move_d = 1'b1; end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      dir_q     <= '0;
      row_q     <= MID;
      col_q     <= MID;
      move_q    <= 1'b0;
      select_q  <= 1'b0;
      sel_row_q <= '0;
      sel_col_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      row_q     <= row_d;
      col_q     <= col_d;
      move_q    <= move_d;
      select_q  <= select_d;
      sel_row_q <= sel_row_d;
      sel_col_q <= sel_col_d;
    end
  end

  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign move_strobe   = move_q;
  assign select_strobe = select_q;
  assign sel_row       = sel_row_q;
  assign sel_col       = sel_col_q;
  assign repeat_active = (state_q == REPEAT);

endmodule

// File: tb/tb_sudoku_cursor_ctrl.sv
// tb/tb_sudoku_cursor_ctrl.sv - self-checking bench for sudoku_cursor_ctrl (wrap and clamp instances)
module tb_sudoku_cursor_ctrl;

  localparam int GRID = 9;
  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_level, btn_pulse;

  logic [3:0] row_o [2];
  logic [3:0] col_o [2];
  logic [3:0] srow_o [2];
  logic [3:0] scol_o [2];
  logic       mv_o [2];
  logic       sel_o [2];
  logic       rep_o [2];

  always #5 clk = ~clk;

  sudoku_cursor_ctrl #(.GRID(GRID), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .cursor_row(row_o[0]), .cursor_col(col_o[0]), .move_strobe(mv_o[0]),
    .select_strobe(sel_o[0]), .sel_row(srow_o[0]), .sel_col(scol_o[0]),
    .repeat_active(rep_o[0]));

  sudoku_cursor_ctrl #(.GRID(GRID), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .WRAP(0)) u_clamp (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .cursor_row(row_o[1]), .cursor_col(col_o[1]), .move_strobe(mv_o[1]),
    .select_strobe(sel_o[1]), .sel_row(srow_o[1]), .sel_col(scol_o[1]),
    .repeat_active(rep_o[1]));

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a press starts an "age" count; moves happen at the press and then
  // whenever the held age reaches HOLD, HOLD+REP, HOLD+2*REP, ...
  int m_row [2], m_col [2], m_sr [2], m_sc [2];
  bit m_mv [2], m_sel [2], m_rep;
  bit active;
  int mdir, age;

  task automatic do_move(input int d);
    for (int i = 0; i < 2; i++) begin
      int r, c;
      r = m_row[i] + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
      c = m_col[i] + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
      if (r >= 0 && r < GRID && c >= 0 && c < GRID) begin
        m_row[i] = r; m_col[i] = c; m_mv[i] = 1;
      end else if (i == 0) begin
        m_row[i] = (r + GRID) % GRID; m_col[i] = (c + GRID) % GRID; m_mv[i] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_row[i] = (GRID - 1) / 2; m_col[i] = (GRID - 1) / 2;
        m_sr[i] = 0; m_sc[i] = 0; m_mv[i] = 0; m_sel[i] = 0;
      end
      m_rep = 0; active = 0; mdir = 0; age = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_mv[i] = 0;
        m_sel[i] = btn_pulse[4];
        if (btn_pulse[4]) begin m_sr[i] = m_row[i]; m_sc[i] = m_col[i]; end
      end
      if (btn_pulse[3:0] != 0) begin
        mdir = btn_pulse[0] ? 0 : btn_pulse[1] ? 1 : btn_pulse[2] ? 2 : 3;
        do_move(mdir);
        active = 1; age = 0;
      end else if (active) begin
        age++;
        if (!btn_level[mdir]) active = 0;
        else if (age >= HOLD && (age - HOLD) % REP == 0) do_move(mdir);
      end
      m_rep = active && age >= HOLD;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc%0d.row", i), 32'(row_o[i]), 32'(m_row[i]));
        chk($sformatf("cyc%0d.col", i), 32'(col_o[i]), 32'(m_col[i]));
        chk($sformatf("cyc%0d.move", i), 32'(mv_o[i]), 32'(m_mv[i]));
        chk($sformatf("cyc%0d.sel", i), 32'(sel_o[i]), 32'(m_sel[i]));
        chk($sformatf("cyc%0d.sel_row", i), 32'(srow_o[i]), 32'(m_sr[i]));
        chk($sformatf("cyc%0d.sel_col", i), 32'(scol_o[i]), 32'(m_sc[i]));
        chk($sformatf("cyc%0d.repeat", i), 32'(rep_o[i]), 32'(m_rep));
      end
    end
  end

  task automatic step(input logic [4:0] lv, input logic [4:0] pl);
    btn_level = lv;
    btn_pulse = pl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    btn_level = '0;
    btn_pulse = '0;
    @(posedge clk);
    #2;
    started = 1;
    chk("reset.row", 32'(row_o[0]), 4);
    chk("reset.col", 32'(col_o[0]), 4);
    chk("reset.move", 32'(mv_o[0]), 0);
    chk("reset.repeat", 32'(rep_o[1]), 0);
    step(5'h00, 5'h00);
    rst_n = 1'b1;
    step(5'h00, 5'h00);

    // Single right press, released later.
    step(5'h08, 5'h08);
    chk("right.col", 32'(col_o[0]), 5);
    chk("right.move", 32'(mv_o[0]), 1);
    step(5'h08, 5'h00);
    chk("right.move_once", 32'(mv_o[0]), 0);
    step(5'h08, 5'h00);
    step(5'h00, 5'h00);
    repeat (4) step(5'h00, 5'h00);
    chk("right.col_stays", 32'(col_o[0]), 5);

    // Up presses to the edge: wrap vs clamp.
    for (int k = 0; k < 4; k++) begin
      step(5'h01, 5'h01);
      chk("up.row", 32'(row_o[0]), 32'(3 - k));
      step(5'h00, 5'h00);
    end
    step(5'h01, 5'h01);
    chk("up.wrap_row", 32'(row_o[0]), 8);
    chk("up.wrap_move", 32'(mv_o[0]), 1);
    chk("up.clamp_row", 32'(row_o[1]), 0);
    chk("up.clamp_move", 32'(mv_o[1]), 0);
    step(5'h00, 5'h00);

    // Hold down from row 0 on the clamp instance.
    step(5'h02, 5'h02);
    chk("hold.first", 32'(row_o[1]), 1);
    repeat (10) step(5'h02, 5'h00);
    chk("hold.rep1_row", 32'(row_o[1]), 2);
    chk("hold.rep1_active", 32'(rep_o[1]), 1);
    repeat (4) step(5'h02, 5'h00);
    chk("hold.rep2_row", 32'(row_o[1]), 3);
    repeat (4) step(5'h02, 5'h00);
    chk("hold.rep3_row", 32'(row_o[1]), 4);
    repeat (2) step(5'h02, 5'h00);
    step(5'h00, 5'h00);
    chk("hold.release_active", 32'(rep_o[1]), 0);
    step(5'h00, 5'h00);
    chk("hold.release_move", 32'(mv_o[1]), 0);
    repeat (3) step(5'h00, 5'h00);

    // Release exactly on the expiry cycle.
    step(5'h02, 5'h02);
    repeat (9) step(5'h02, 5'h00);
    step(5'h00, 5'h00);
    chk("expiry.row", 32'(row_o[1]), 5);
    chk("expiry.move", 32'(mv_o[1]), 0);
    repeat (6) step(5'h00, 5'h00);
    chk("expiry.row_idle", 32'(row_o[1]), 5);

    // Back to centre, then same-cycle arbitration and select.
    rst_n = 1'b0;
    step(5'h00, 5'h00);
    rst_n = 1'b1;
    step(5'h00, 5'h00);
    step(5'h05, 5'h05);
    chk("arb.row", 32'(row_o[0]), 3);
    chk("arb.col", 32'(col_o[0]), 4);
    step(5'h00, 5'h00);
    step(5'h08, 5'h18);
    chk("sel.strobe", 32'(sel_o[0]), 1);
    chk("sel.row", 32'(srow_o[0]), 3);
    chk("sel.col", 32'(scol_o[0]), 4);
    chk("sel.cursor_col", 32'(col_o[0]), 5);
    step(5'h00, 5'h00);
    chk("sel.once", 32'(sel_o[0]), 0);

    // Reset in the middle of a repeat with the level still held.
    step(5'h04, 5'h04);
    repeat (12) step(5'h04, 5'h00);
    chk("rst.in_repeat", 32'(rep_o[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst.async_row", 32'(row_o[0]), 4);
    chk("rst.async_col", 32'(col_o[0]), 4);
    chk("rst.async_repeat", 32'(rep_o[0]), 0);
    step(5'h04, 5'h00);
    rst_n = 1'b1;
    repeat (30) step(5'h04, 5'h00);
    chk("rst.no_move_col", 32'(col_o[0]), 4);
    chk("rst.no_move_strobe", 32'(mv_o[1]), 0);
    step(5'h00, 5'h00);

    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
